guia_0704_seq: RTL and testbench
================================

GUIA_0704_SEQ -- requirements
Module: guia_0704_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; ports in order:
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a full 16-vector run; sampled only in IDLE.
REQ-005 hold  input  1  freezes the run while high; ignored in IDLE and DONE.
REQ-006 result  input  1  output of the downstream AND/OR/NAND/NOR selectable logic unit.
REQ-007 a, b, chave1, chave2  output  1 each  registered operands and operation select driven to the logic unit.
REQ-008 busy  output  1  high in DRIVE and SAMPLE.
REQ-009 done  output  1  one-cycle pulse in DONE.
REQ-010 vec_idx  output  4  index of the current vector.
REQ-011 err_count  output  5  mismatches in the current or last run, range 0..16.
REQ-012 pass  output  1  registered; high from DONE until the next start when err_count==0.

Function
REQ-013 {a,b,chave1,chave2} SHALL equal vec_idx[3:0], MSB first.
REQ-014 Select encoding SHALL be {chave1,chave2}: 00 AND, 01 OR, 10 NAND, 11 NOR.
REQ-015 FSM states SHALL be IDLE, DRIVE, SAMPLE and DONE.
REQ-016 IDLE with start=1 SHALL go to DRIVE, clear vec_idx, err_count and pass, and drive vector 0 after the same edge.
REQ-017 DRIVE SHALL go to SAMPLE on the next edge, giving the combinational unit one full cycle to settle.
REQ-018 On leaving SAMPLE, the FSM SHALL compare result with the expected value and increment err_count on mismatch.
REQ-019 From SAMPLE, the FSM SHALL go to DRIVE with vec_idx+1, or to DONE when vec_idx==15.
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-021 A run without hold SHALL take 32 cycles from the start edge to the DONE edge.
REQ-022 hold=1 in DRIVE or SAMPLE SHALL freeze the state, vec_idx and outputs, and SHALL perform no compare.
REQ-023 start while busy or in DONE SHALL be ignored.
REQ-024 vec_idx SHALL NOT wrap past 15.
REQ-025 err_count SHALL stay at or below 16 without needing saturation logic.
REQ-026 In IDLE, the operand outputs SHALL hold the last vector driven.

Reset
REQ-027 Asserting rst_n low SHALL force IDLE immediately, at any time including mid-run.
REQ-028 Reset SHALL set a, b, chave1, chave2, busy, done, pass, vec_idx and err_count to 0.
REQ-029 A run after reset SHALL restart from vector 0; no partial state is retained.

Configuration
REQ-030 Macro GUIA_SEQ_SELFCHECK_EN defined: expected-value model, compare and err_count SHALL be compiled in, and pass behaves as in REQ-012.
REQ-031 Macro GUIA_SEQ_SELFCHECK_EN undefined: no compare logic; err_count SHALL be constant 0 and pass SHALL be high in DONE and after it until the next start.
REQ-032 Sequencing and timing SHALL be identical with and without the macro.

Structure
REQ-033 Shared package guia_seq_pkg SHALL hold the state typedef (IDLE/DRIVE/SAMPLE/DONE), the 2-bit operation codes OP_AND/OP_OR/OP_NAND/OP_NOR, and LAST_IDX=15.
REQ-034 The expected-value function SHALL be one combinational sub-module, guia_logic_ref, with inputs a, b, sel[1:0] and output exp; it is instantiated only under the macro.

Verification
REQ-035 Reset, then start pulse with a correct logic unit -> done at cycle 32 after start, err_count=0, pass=1.
REQ-036 result stuck at 0 -> err_count=8 at done (expected ones: AND 1, OR 3, NAND 3, NOR 1), pass=0.
REQ-037 hold high for 4 cycles while vec_idx=5 -> outputs frozen, done at cycle 36, err_count=0.
REQ-038 rst_n low during vec_idx=9 -> all outputs 0 at once; new start -> vec_idx=0, full 32-cycle run.
REQ-039 start re-pulsed at vec_idx=3 and during DONE -> ignored; single done pulse, vec_idx sequence unbroken.
REQ-040 Build without GUIA_SEQ_SELFCHECK_EN, result stuck at 0 -> err_count=0, pass=1 at done.

Source files
------------

// File: rtl/guia_seq_pkg.sv
// guia_seq_pkg: shared FSM states, logic-unit operation codes and last vector index.
package guia_seq_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;
    localparam logic [3:0] LAST_IDX = 4'd15;
endpackage

// File: rtl/guia_logic_ref.sv
// guia_logic_ref: expected output of the AND/OR/NAND/NOR logic unit.
module guia_logic_ref
    import guia_seq_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [1:0] sel,
    output logic       exp
);
    always_comb exp = sel == OP_AND  ?  (a & b) :
                      sel == OP_OR   ?  (a | b) :
                      sel == OP_NAND ? ~(a & b) : ~(a | b);
endmodule

// File: rtl/guia_0704_seq.sv
// guia_0704_seq: 16-vector logic-unit sequencer; GUIA_SEQ_SELFCHECK_EN adds compare and err_count.
module guia_0704_seq
    import guia_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hold,
    input  logic       result,
    output logic       a,
    output logic       b,
    output logic       chave1,
    output logic       chave2,
    output logic       busy,
    output logic       done,
    output logic [3:0] vec_idx,
    output logic [4:0] err_count,
    output logic       pass
);
    state_t     state, state_nxt;
    logic [3:0] idx_nxt;
    logic [4:0] err_nxt;
    logic       pass_nxt;
    logic       mismatch;
`ifdef GUIA_SEQ_SELFCHECK_EN
    logic exp;
    guia_logic_ref u_ref (
        .a   (a),
        .b   (b),
        .sel ({chave1, chave2}),
        .exp (exp)
    );
    assign mismatch = result != exp;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) err_count <= '0;
        else        err_count <= err_nxt;
`else
    logic unused_result;
    assign unused_result = result;
    assign mismatch = 1'b0;
    assign err_count = '0;
`endif
    assign {a, b, chave1, chave2} = vec_idx;
    assign busy = state == DRIVE || state == SAMPLE;
    assign done = state == DONE;
    // err_nxt stays 0 without the checker, so pass rises unconditionally at DONE
    always_comb begin
        state_nxt = state;
        idx_nxt   = vec_idx;
        err_nxt   = err_count;
        pass_nxt  = pass;
        case (state)
            IDLE: if (start) begin
                state_nxt = DRIVE;
                idx_nxt   = '0;
                err_nxt   = '0;
                pass_nxt  = 1'b0;
            end
            DRIVE: state_nxt = hold ? DRIVE : SAMPLE;
            SAMPLE: if (!hold) begin
                err_nxt   = err_count + {4'd0, mismatch};
                state_nxt = vec_idx == LAST_IDX ? DONE : DRIVE;
                idx_nxt   = vec_idx == LAST_IDX ? vec_idx : vec_idx + 4'd1;
                pass_nxt  = vec_idx == LAST_IDX ? err_nxt == '0 : pass;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            vec_idx <= '0;
            pass    <= 1'b0;
        end else begin
            state   <= state_nxt;
            vec_idx <= idx_nxt;
            pass    <= pass_nxt;
        end
endmodule

// File: tb/tb_guia_0704_seq.sv
// tb_guia_0704_seq: randomized scoreboard bench with a phase-counter reference model.
module tb_guia_0704_seq;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hold = 1'b0, result;
    logic a, b, chave1, chave2, busy, done, pass;
    logic [3:0] vec_idx;
    logic [4:0] err_count;
    logic stuck0 = 1'b0;
    logic [15:0] flip = '0;
    int n_cmp = 0, n_bad = 0;
    int ph = -1, cyc = 0, m_start = 0;
    logic [3:0] m_idx = '0;
    typedef struct {int err; int pass; int cycles;} exp_t;
    exp_t sbq[$];
    exp_t e_mon;

    guia_0704_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .result(result),
        .a(a), .b(b), .chave1(chave1), .chave2(chave2), .busy(busy), .done(done),
        .vec_idx(vec_idx), .err_count(err_count), .pass(pass)
    );

    always #5 clk = ~clk;

    function automatic logic op(input logic x, input logic y, input logic [1:0] s);
        return s == 2'd0 ? (x & y) : s == 2'd1 ? (x | y) : s == 2'd2 ? !(x & y) : !(x | y);
    endfunction

    // the downstream unit: correct, stuck at 0, or wrong on the vectors marked in flip
    always_comb result = stuck0 ? 1'b0 : op(a, b, {chave1, chave2}) ^ flip[{a, b, chave1, chave2}];

    function automatic int exp_err(input logic s0, input logic [15:0] fl);
        int n;
        logic [3:0] q;
        logic good, got;
        n = 0;
        for (int v = 0; v < 16; v++) begin
            q = 4'(v);
            good = op(q[3], q[2], q[1:0]);
            got = s0 ? 1'b0 : good ^ fl[v];
            n += int'(got != good);
        end
`ifdef GUIA_SEQ_SELFCHECK_EN
        return n;
`else
        return n * 0;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // run model: phases 0..31 are two per vector, phase 32 is the done cycle
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ph <= -1;
            m_idx <= '0;
        end else begin
            cyc <= cyc + 1;
            if (ph < 0) begin
                if (start) begin
                    ph <= 0;
                    m_idx <= '0;
                    m_start <= cyc + 1;
                end
            end else if (ph == 32) ph <= -1;
            else if (!hold) begin
                ph <= ph + 1;
                if (ph < 31) m_idx <= 4'((ph + 1) / 2);
            end
        end

    always @(negedge clk)
        if (rst_n) begin
            chk("busy", int'(busy), int'(ph >= 0 && ph < 32));
            chk("done", int'(done), int'(ph == 32));
            chk("vec_idx", int'(vec_idx), int'(m_idx));
            chk("operands", int'({a, b, chave1, chave2}), int'(m_idx));
            if (done) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done, expected none (t=%0t)", $time);
                end else begin
                    e_mon = sbq.pop_front();
                    chk("err_count", int'(err_count), e_mon.err);
                    chk("pass", int'(pass), e_mon.pass);
                    chk("run_cycles", cyc - m_start, e_mon.cycles);
                end
            end
        end

    task automatic chk_zero(input string tag);
        chk({tag, "_a"}, int'(a), 0);
        chk({tag, "_b"}, int'(b), 0);
        chk({tag, "_chave1"}, int'(chave1), 0);
        chk({tag, "_chave2"}, int'(chave2), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_vec_idx"}, int'(vec_idx), 0);
        chk({tag, "_err_count"}, int'(err_count), 0);
    endtask

    task automatic run(input logic s0, input logic [15:0] fl, input int hold_at, input int hold_len, input logic extra);
        int e, ep;
        logic got, held, x3;
        got = 1'b0; held = 1'b0; x3 = 1'b0;
        stuck0 = s0;
        flip = fl;
        e = exp_err(s0, fl);
        ep = int'(e == 0);
        sbq.push_back(exp_t'{e, ep, 32 + (hold_len > 0 ? hold_len : 0)});
        @(negedge clk) start = 1'b1;
        @(posedge clk) #2 start = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                if (extra) begin
                    start = 1'b1;
                    @(posedge clk) #2 start = 1'b0;
                end
            end else if (hold_len > 0 && !held && vec_idx == 4'(hold_at)) begin
                held = 1'b1;
                hold = 1'b1;
                repeat (hold_len) @(posedge clk);
                #2 hold = 1'b0;
            end else if (extra && !x3 && vec_idx == 4'd3) begin
                x3 = 1'b1;
                start = 1'b1;
                @(posedge clk) #2 start = 1'b0;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_timeout: got no done, expected done within 200 cycles");
        end
        repeat (extra ? 40 : 3) @(negedge clk);
        chk("pass_idle", int'(pass), ep);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_zero("reset");
        run(1'b0, 16'h0, -1, 0, 1'b0);
        run(1'b1, 16'h0, -1, 0, 1'b0);
        run(1'b0, 16'h0, 5, 4, 1'b0);
        @(negedge clk) start = 1'b1;
        @(posedge clk) #2 start = 1'b0;
        for (int i = 0; i < 100 && vec_idx != 4'd9; i++) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_zero("midrun_reset");
        @(posedge clk) #2 rst_n = 1'b1;
        run(1'b0, 16'h0, -1, 0, 1'b0);
        run(1'b0, 16'h0, -1, 0, 1'b1);
        for (int k = 0; k < 5; k++)
            run(1'($urandom_range(0, 1) == 0 && k == 4), 16'($urandom), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 5)), 1'b0);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
